// File: rtl/product_accumulator_if.sv
// Product stream in / accumulated result out, grouped as one bus.
// The slave modport is the accumulator's view; the master modport is the
// view of whatever sources terms and sinks results.
interface product_accumulator_if #(
    parameter int PROD_W  = 16,
    parameter int ACC_W   = 24,
    parameter int N_TERMS = 8
);
    localparam int CNT_W = $clog2(N_TERMS + 1);

    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] in_product;
    logic              in_src;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_sum;
    logic [CNT_W-1:0]  out_count;
    logic              out_overflow;
    logic [1:0]        out_src_mask;

    modport slave (
        input  in_valid, in_product, in_src, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_count, out_overflow, out_src_mask
    );

    modport master (
        output in_valid, in_product, in_src, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_count, out_overflow, out_src_mask
    );
endinterface

// File: rtl/product_accumulator.sv
// Sums up to N_TERMS unsigned products into a wide accumulator and offers the
// finished sum on a valid/ready port. A result closes early on in_last.
// Result fields are the live registers; they only mean something with out_valid.
module product_accumulator #(
    parameter int PROD_W  = 16,
    parameter int ACC_W   = 24,   // must be >= PROD_W
    parameter int N_TERMS = 8,    // must be >= 1
    parameter bit SAT     = 1'b1  // 1: clamp to all-ones on overflow, 0: wrap
) (
    input  logic clk,
    input  logic rst_n,
    product_accumulator_if.slave bus
);
    localparam int CNT_W = $clog2(N_TERMS + 1);

    typedef enum logic {ACCUM = 1'b0, DONE = 1'b1} state_e;

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic [1:0]         mask_q, mask_d;

    logic               accept;
    logic               release_res;
    logic [ACC_W:0]     sum_ext;
    logic               sum_ovf;
    logic [CNT_W-1:0]   cnt_inc;
    logic               close_res;

    // Handshake qualifiers; both ports are held off while reset is asserted.
    assign bus.in_ready  = rst_n && (state_q == ACCUM);
    assign bus.out_valid = rst_n && (state_q == DONE);
    assign accept        = bus.in_valid && bus.in_ready;
    assign release_res   = bus.out_valid && bus.out_ready;

    // One extra bit catches the carry out of the accumulator.
    assign sum_ext  = {1'b0, acc_q} + {{(ACC_W + 1 - PROD_W){1'b0}}, bus.in_product};
    assign sum_ovf  = sum_ext[ACC_W];
    assign cnt_inc  = cnt_q + CNT_W'(1);
    assign close_res = bus.in_last || (cnt_inc == CNT_W'(N_TERMS));

    assign bus.out_sum      = acc_q;
    assign bus.out_count    = cnt_q;
    assign bus.out_overflow = ovf_q;
    assign bus.out_src_mask = mask_q;

    // Next-state: accumulate in ACCUM, hold in DONE until the result is taken.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        mask_d  = mask_q;
        unique case (state_q)
            ACCUM: begin
                if (accept) begin
                    // Once clamped, any further nonzero term overflows again,
                    // so the saturated value holds for the rest of the result.
                    if (sum_ovf && SAT) acc_d = {ACC_W{1'b1}};
                    else                acc_d = sum_ext[ACC_W-1:0];
                    ovf_d               = ovf_q | sum_ovf;
                    cnt_d               = cnt_inc;
                    mask_d[bus.in_src]  = 1'b1;
                    if (close_res) state_d = DONE;
                end
            end
            DONE: begin
                if (release_res) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    mask_d  = 2'b00;
                    state_d = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    // State registers; reset drops any partial sum or pending result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            mask_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            mask_q  <= mask_d;
        end
    end
endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench: one N_TERMS=4/ACC_W=24/SAT=1 instance for the main sequence,
// plus two ACC_W=17 instances (SAT=1 and SAT=0) driven in lockstep for overflow.
module tb_product_accumulator;
    logic clk;
    logic rst_n;
    int   vectors = 0;
    int   errs    = 0;

    product_accumulator_if #(.PROD_W(16), .ACC_W(24), .N_TERMS(4)) ifa ();
    product_accumulator_if #(.PROD_W(16), .ACC_W(17), .N_TERMS(4)) ifb ();
    product_accumulator_if #(.PROD_W(16), .ACC_W(17), .N_TERMS(4)) ifc ();

    product_accumulator #(.PROD_W(16), .ACC_W(24), .N_TERMS(4), .SAT(1'b1))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    product_accumulator #(.PROD_W(16), .ACC_W(17), .N_TERMS(4), .SAT(1'b1))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
    product_accumulator #(.PROD_W(16), .ACC_W(17), .N_TERMS(4), .SAT(1'b0))
        dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; all driving and sampling happens 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_a(input logic v, input logic [15:0] p, input logic s, input logic l);
        ifa.in_valid   = v;
        ifa.in_product = p;
        ifa.in_src     = s;
        ifa.in_last    = l;
    endtask

    initial begin
        rst_n = 1'b0;
        drive_a(1'b0, 16'h0, 1'b0, 1'b0);
        ifa.out_ready  = 1'b1;
        ifb.in_valid   = 1'b0; ifb.in_product = '0; ifb.in_src = 1'b1; ifb.in_last = 1'b0;
        ifb.out_ready  = 1'b1;
        ifc.in_valid   = 1'b0; ifc.in_product = '0; ifc.in_src = 1'b1; ifc.in_last = 1'b0;
        ifc.out_ready  = 1'b1;

        // Reset: both handshake outputs held low while rst_n=0.
        tick(); tick();
        chk("rst_in_ready", 32'(ifa.in_ready), 32'd0);
        chk("rst_out_valid", 32'(ifa.out_valid), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_in_ready", 32'(ifa.in_ready), 32'd1);
        chk("post_rst_sum", 32'(ifa.out_sum), 32'd0);
        chk("post_rst_count", 32'(ifa.out_count), 32'd0);
        chk("post_rst_mask", 32'(ifa.out_src_mask), 32'd0);

        // 1: four terms back-to-back closes on count, latency 1 to out_valid.
        drive_a(1'b1, 16'h0010, 1'b1, 1'b0); tick();
        drive_a(1'b1, 16'h0020, 1'b1, 1'b0); tick();
        drive_a(1'b1, 16'h0030, 1'b1, 1'b0); tick();
        chk("t1_valid_before", 32'(ifa.out_valid), 32'd0);
        drive_a(1'b1, 16'h0040, 1'b1, 1'b0); tick();
        drive_a(1'b0, 16'h0, 1'b0, 1'b0);
        chk("t1_valid", 32'(ifa.out_valid), 32'd1);
        chk("t1_in_ready", 32'(ifa.in_ready), 32'd0);
        chk("t1_sum", 32'(ifa.out_sum), 32'h0000A0);
        chk("t1_count", 32'(ifa.out_count), 32'd4);
        chk("t1_ovf", 32'(ifa.out_overflow), 32'd0);
        chk("t6_mask_all1", 32'(ifa.out_src_mask), 32'b10);
        tick();
        chk("t1_released", 32'(ifa.out_valid), 32'd0);
        chk("t1_cleared", 32'(ifa.out_sum), 32'd0);

        // in_last without in_valid must not close anything.
        drive_a(1'b0, 16'd77, 1'b0, 1'b1); tick();
        chk("last_no_valid", 32'(ifa.out_valid), 32'd0);
        chk("idle_count", 32'(ifa.out_count), 32'd0);

        // 2: early close on in_last, then a held term waits out the bubble.
        drive_a(1'b1, 16'd100, 1'b0, 1'b0); tick();
        drive_a(1'b1, 16'd200, 1'b0, 1'b1); tick();
        drive_a(1'b1, 16'd5, 1'b0, 1'b0);
        chk("t2_valid", 32'(ifa.out_valid), 32'd1);
        chk("t2_sum", 32'(ifa.out_sum), 32'd300);
        chk("t2_count", 32'(ifa.out_count), 32'd2);
        tick();   // handshake edge, term 5 not taken
        chk("t2_bubble_count", 32'(ifa.out_count), 32'd0);
        chk("t2_ready_back", 32'(ifa.in_ready), 32'd1);
        tick();   // term 5 accepted
        drive_a(1'b0, 16'h0, 1'b0, 1'b0);
        chk("t2_next_sum", 32'(ifa.out_sum), 32'd5);
        chk("t2_next_count", 32'(ifa.out_count), 32'd1);

        // 4: stalled result with a waiting term.
        ifa.out_ready = 1'b0;
        drive_a(1'b1, 16'd7, 1'b0, 1'b1); tick();
        drive_a(1'b1, 16'd9, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            chk("t4_stall_ready", 32'(ifa.in_ready), 32'd0);
            chk("t4_stall_valid", 32'(ifa.out_valid), 32'd1);
            chk("t4_stall_sum", 32'(ifa.out_sum), 32'd12);
            chk("t4_stall_count", 32'(ifa.out_count), 32'd2);
            tick();
        end
        chk("t4_stall_sum_end", 32'(ifa.out_sum), 32'd12);
        ifa.out_ready = 1'b1;
        tick();   // handshake
        chk("t4_released", 32'(ifa.out_valid), 32'd0);
        tick();   // held term 9 accepted
        chk("t4_held_sum", 32'(ifa.out_sum), 32'd9);
        drive_a(1'b1, 16'd1, 1'b0, 1'b1); tick();
        drive_a(1'b0, 16'h0, 1'b0, 1'b0);
        chk("t4_next_sum", 32'(ifa.out_sum), 32'd10);
        chk("t4_next_count", 32'(ifa.out_count), 32'd2);
        tick();

        // 5: reset in the middle of a partial sum discards it.
        drive_a(1'b1, 16'd50, 1'b0, 1'b0); tick();
        drive_a(1'b1, 16'd50, 1'b0, 1'b0); tick();
        drive_a(1'b0, 16'h0, 1'b0, 1'b0);
        chk("t5_partial", 32'(ifa.out_sum), 32'd100);
        rst_n = 1'b0;
        tick();
        chk("t5_rst_ready", 32'(ifa.in_ready), 32'd0);
        rst_n = 1'b1;
        chk("t5_rst_sum", 32'(ifa.out_sum), 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk("t5_no_early_result", 32'(ifa.out_valid), 32'd0);
            drive_a(1'b1, 16'd1, 1'b0, 1'b0); tick();
        end
        drive_a(1'b0, 16'h0, 1'b0, 1'b0);
        chk("t5_valid", 32'(ifa.out_valid), 32'd1);
        chk("t5_sum", 32'(ifa.out_sum), 32'd4);
        chk("t5_count", 32'(ifa.out_count), 32'd4);
        tick();

        // 6: mixed sources set both mask bits.
        drive_a(1'b1, 16'd1, 1'b1, 1'b0); tick();
        drive_a(1'b1, 16'd1, 1'b0, 1'b0); tick();
        drive_a(1'b1, 16'd1, 1'b1, 1'b0); tick();
        drive_a(1'b1, 16'd1, 1'b1, 1'b0); tick();
        drive_a(1'b0, 16'h0, 1'b0, 1'b0);
        chk("t6_mask_mixed", 32'(ifa.out_src_mask), 32'b11);
        tick();

        // 3: ACC_W=17 overflow, saturating vs wrapping.
        ifb.in_valid = 1'b1; ifb.in_product = 16'hFFFF;
        ifc.in_valid = 1'b1; ifc.in_product = 16'hFFFF;
        tick(); tick();
        chk("t3_b_two", 32'(ifb.out_sum), 32'h1FFFE);
        chk("t3_b_two_ovf", 32'(ifb.out_overflow), 32'd0);
        tick();
        chk("t3_b_three", 32'(ifb.out_sum), 32'h1FFFF);
        chk("t3_c_three", 32'(ifc.out_sum), 32'h0FFFD);
        chk("t3_c_three_ovf", 32'(ifc.out_overflow), 32'd1);
        tick();
        ifb.in_valid = 1'b0;
        ifc.in_valid = 1'b0;
        chk("t3_b_valid", 32'(ifb.out_valid), 32'd1);
        chk("t3_b_sum", 32'(ifb.out_sum), 32'h1FFFF);
        chk("t3_b_ovf", 32'(ifb.out_overflow), 32'd1);
        chk("t3_c_sum", 32'(ifc.out_sum), 32'h1FFFC);
        chk("t3_c_ovf", 32'(ifc.out_overflow), 32'd1);
        tick();
        chk("t3_b_cleared_ovf", 32'(ifb.out_overflow), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
